// File: rtl/hex_word_ascii_streamer_if.sv
// Word-in / ASCII-byte-out handshake bundle for hex_word_ascii_streamer.
interface hex_word_ascii_streamer_if #(
  parameter int unsigned NIBBLES = 8
);
  logic [4*NIBBLES-1:0] In_Word;
  logic                 In_Valid;
  logic                 In_Ready;
  logic [7:0]           Out_Char;
  logic                 Out_Valid;
  logic                 Out_Ready;

  modport master (
    output In_Word, In_Valid, Out_Ready,
    input  In_Ready, Out_Char, Out_Valid
  );

  modport slave (
    input  In_Word, In_Valid, Out_Ready,
    output In_Ready, Out_Char, Out_Valid
  );
endinterface

// File: rtl/hex_word_ascii_streamer.sv
// Prints one binary word as uppercase ASCII hex (MS nibble first), optionally
// followed by CR/LF, over a valid/ready byte stream.
module hex_word_ascii_streamer #(
  parameter int unsigned NIBBLES     = 8,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  hex_word_ascii_streamer_if.slave    bus,
  output logic                        Busy
);

  localparam int unsigned WORD_W = 4 * NIBBLES;
  localparam int unsigned IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEX,
    ST_CR,
    ST_LF
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [7:0]         char_q, char_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               in_hs, out_hs;
  logic [IDX_W-1:0]   idx_dec;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble_at(input logic [WORD_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
    nibble_at = 4'h0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (i == IDX_W'(k)) nibble_at = w[4*k +: 4];
    end
  endfunction

  assign in_hs   = bus.In_Valid & ready_q;
  assign out_hs  = valid_q & bus.Out_Ready;
  assign idx_dec = idx_q - IDX_ONE;

  // Next-state and next-output logic; index 0 is always the last digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    char_d  = char_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          word_d  = bus.In_Word;
          idx_d   = IDX_LAST;
          char_d  = hex_ascii(bus.In_Word[WORD_W-1 -: 4]);
          valid_d = 1'b1;
          state_d = ST_HEX;
        end
      end
      ST_HEX: begin
        if (out_hs) begin
          if (idx_q != '0) begin
            idx_d  = idx_dec;
            char_d = hex_ascii(nibble_at(word_q, idx_dec));
          end else if (APPEND_CRLF) begin
            char_d  = 8'h0D;
            state_d = ST_CR;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CR: begin
        if (out_hs) begin
          char_d  = 8'h0A;
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (out_hs) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.In_Ready  = ready_q;
  assign bus.Out_Char  = char_q;
  assign bus.Out_Valid = valid_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_hex_word_ascii_streamer.sv
// Randomized self-checking bench for hex_word_ascii_streamer against a
// string-level reference model.
module tb_hex_word_ascii_streamer;

  logic Clk;
  logic Rst;
  logic Busy0, Busy1;

  hex_word_ascii_streamer_if #(.NIBBLES(8)) bus0 ();
  hex_word_ascii_streamer_if #(.NIBBLES(2)) bus1 ();

  hex_word_ascii_streamer #(.NIBBLES(8), .APPEND_CRLF(1'b1)) dut0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus0),
    .Busy(Busy0)
  );

  hex_word_ascii_streamer #(.NIBBLES(2), .APPEND_CRLF(1'b0)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus1),
    .Busy(Busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Expected byte string: hex digits MS first, optional CR LF.
  function automatic void build_exp(input logic [63:0] w, input int nib, input bit crlf);
    exp_q.delete();
    for (int i = nib - 1; i >= 0; i--) begin
      int d;
      d = int'((w >> (4 * i)) & 64'hF);
      if (d < 10) exp_q.push_back(8'(48 + d));
      else        exp_q.push_back(8'(65 + d - 10));
    end
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic accept0(input logic [31:0] w, input bit keep);
    int n = 0;
    while (!bus0.In_Ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_ready", 64'(bus0.In_Ready), 64'd1);
    bus0.In_Word  = w;
    bus0.In_Valid = 1'b1;
    step();
    if (!keep) bus0.In_Valid = 1'b0;
    chk("first_valid", 64'(bus0.Out_Valid), 64'd1);
  endtask

  // stall: 0 = always ready, 1 = random ready plus input noise, 2 = 1-0-0-1 pattern
  task automatic recv0(input logic [31:0] w, input int stall);
    int k = 0;
    int cyc = 0;
    bit was_stall = 1'b0;
    bit r;
    logic [7:0] held = 8'h00;
    build_exp(64'(w), 8, 1'b1);
    while (k < int'(exp_q.size()) && cyc < 400) begin
      chk("busy_during", 64'(Busy0), 64'd1);
      chk("in_ready_low", 64'(bus0.In_Ready), 64'd0);
      chk("valid_during", 64'(bus0.Out_Valid), 64'd1);
      if (was_stall) chk("stall_hold", 64'(bus0.Out_Char), 64'(held));
      if (stall == 1) begin
        r = 1'($urandom_range(0, 1));
        bus0.In_Valid = 1'($urandom_range(0, 1));
        bus0.In_Word  = $urandom;
      end else if (stall == 2) begin
        r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end else begin
        r = 1'b1;
      end
      bus0.Out_Ready = r;
      if (r) begin
        chk("char", 64'(bus0.Out_Char), 64'(exp_q[k]));
        k++;
        was_stall = 1'b0;
      end else begin
        held = bus0.Out_Char;
        was_stall = 1'b1;
      end
      step();
      cyc++;
    end
    if (stall == 1) bus0.In_Valid = 1'b0;
    bus0.Out_Ready = 1'b1;
    chk("string_done", 64'(k), 64'(exp_q.size()));
    if (stall == 0) chk("string_cycles", 64'(cyc), 64'(exp_q.size()));
    chk("end_valid", 64'(bus0.Out_Valid), 64'd0);
    chk("end_busy", 64'(Busy0), 64'd0);
    chk("end_ready", 64'(bus0.In_Ready), 64'd1);
  endtask

  task automatic run1(input logic [7:0] w);
    chk("t6_ready", 64'(bus1.In_Ready), 64'd1);
    bus1.In_Word  = w;
    bus1.In_Valid = 1'b1;
    bus1.Out_Ready = 1'b1;
    step();
    bus1.In_Valid = 1'b0;
    got_q.delete();
    for (int c = 0; c < 8; c++) begin
      if (bus1.Out_Valid) got_q.push_back(bus1.Out_Char);
      step();
    end
    build_exp(64'(w), 2, 1'b0);
    chk("t6_len", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < int'(exp_q.size()) && i < int'(got_q.size()); i++)
      chk("t6_char", 64'(got_q[i]), 64'(exp_q[i]));
    chk("t6_idle_busy", 64'(Busy1), 64'd0);
    chk("t6_idle_valid", 64'(bus1.Out_Valid), 64'd0);
  endtask

  initial begin
    logic [31:0] w, w2;
    Rst = 1'b1;
    bus0.In_Word = '0; bus0.In_Valid = 1'b0; bus0.Out_Ready = 1'b1;
    bus1.In_Word = '0; bus1.In_Valid = 1'b0; bus1.Out_Ready = 1'b1;
    step(); step(); step();
    chk("rst_valid", 64'(bus0.Out_Valid), 64'd0);
    chk("rst_char", 64'(bus0.Out_Char), 64'h00);
    chk("rst_ready", 64'(bus0.In_Ready), 64'd1);
    chk("rst_busy", 64'(Busy0), 64'd0);
    chk("rst_ready1", 64'(bus1.In_Ready), 64'd1);
    chk("rst_valid1", 64'(bus1.Out_Valid), 64'd0);
    Rst = 1'b0;
    step();

    // T1: full-rate string
    accept0(32'h0123ABCF, 1'b0);
    recv0(32'h0123ABCF, 0);
    // T2: 1-0-0-1 backpressure
    accept0(32'h0123ABCF, 1'b0);
    recv0(32'h0123ABCF, 2);
    // T3: boundary words
    accept0(32'h00000000, 1'b0);
    recv0(32'h00000000, 0);
    accept0(32'hFFFFFFFF, 1'b0);
    recv0(32'hFFFFFFFF, 0);

    // T4: In_Valid held with a second word while busy
    w = 32'h89ABCDEF;
    w2 = 32'h13579BDF;
    accept0(w, 1'b1);
    bus0.In_Word = w2;
    recv0(w, 0);
    chk("t4_bubble_valid", 64'(bus0.Out_Valid), 64'd0);
    step();
    bus0.In_Valid = 1'b0;
    chk("t4_second_valid", 64'(bus0.Out_Valid), 64'd1);
    recv0(w2, 0);

    // T5: reset after the third character
    w = 32'hDEADBEEF;
    accept0(w, 1'b0);
    build_exp(64'(w), 8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus0.Out_Ready = 1'b1;
      chk("t5_char", 64'(bus0.Out_Char), 64'(exp_q[i]));
      step();
    end
    bus0.Out_Ready = 1'b0;
    Rst = 1'b1;
    step();
    chk("t5_rst_valid", 64'(bus0.Out_Valid), 64'd0);
    chk("t5_rst_busy", 64'(Busy0), 64'd0);
    chk("t5_rst_char", 64'(bus0.Out_Char), 64'h00);
    Rst = 1'b0;
    bus0.Out_Ready = 1'b1;
    step();
    chk("t5_ready", 64'(bus0.In_Ready), 64'd1);
    chk("t5_no_flush", 64'(bus0.Out_Valid), 64'd0);
    accept0(32'h2468ACE1, 1'b0);
    recv0(32'h2468ACE1, 0);

    // Random words with random backpressure and ignored input noise
    for (int n = 0; n < 25; n++) begin
      w = $urandom;
      accept0(w, 1'b0);
      recv0(w, int'($urandom_range(0, 1)));
    end

    // T6: two-digit instance without CR/LF
    run1(8'h9A);
    for (int n = 0; n < 6; n++) run1(8'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
